// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, word geometry
// and the address-legality helper used when a latched request is checked.
package mips_mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam int WORD_BYTES = 4;
    localparam int CNT_WIDTH  = 4;

    // A request is rejected when it is not word aligned or reaches past the RAM.
    function automatic logic addr_rejected(input logic [31:0] a, input int addr_width);
        logic bad;
        bad = (a[1:0] != 2'b00);
        for (int i = 2; i < 32; i++) begin
            if (i >= addr_width + 2 && a[i]) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word RAM with combinational read and synchronous byte-enabled write.
// Contents are never cleared; only the responder decides when a write happens.
module dmem_ram
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the processor load/store port: accepts one request,
// inserts WAIT_CYCLES wait states, then strobes ready with data or err.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("dmem_responder: WAIT_CYCLES must be in 0..15");
    end

    localparam logic [CNT_WIDTH-1:0] WAIT_INIT = CNT_WIDTH'(WAIT_CYCLES);

    // Handshake: req is held by the requester until ready; a request is taken at
    // the first IDLE edge with req=1, and ready is a one-cycle completion strobe
    // (err qualifies it). Inputs are latched at acceptance and ignored afterwards.
    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 we_q;
    logic [31:0]          addr_q;
    logic [31:0]          wdata_q;
    logic [3:0]           be_q;
    logic                 bad;
    logic                 access;
    logic                 ram_we;
    logic [31:0]          ram_rdata;

    assign bad    = addr_rejected(addr_q, ADDR_WIDTH);
    assign access = (state == ST_BUSY) && (cnt == '0);
    // Gating with reset keeps an aborted transaction from touching the RAM.
    assign ram_we = reset && access && we_q && !bad;

    always_ff @(posedge clk) begin
        if (reset && state == ST_IDLE && req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ready <= 1'b0;
                    err   <= 1'b0;
                    if (req) begin
                        cnt   <= WAIT_INIT;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= ST_DONE;
                        ready <= 1'b1;
                        err   <= bad;
                        if (bad)        rdata <= '0;
                        else if (!we_q) rdata <= ram_rdata;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    ready <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b0;
                    err   <= 1'b0;
                end
            endcase
        end
    end

    dmem_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (be_q),
        .addr  (addr_q[ADDR_WIDTH+1:2]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with WAIT_CYCLES=2 and one
// with WAIT_CYCLES=0, checked against hand-computed expected values.
module tb_dmem_responder;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req_v;
    logic [1:0]        we_v;
    logic [1:0][31:0]  addr_v;
    logic [1:0][31:0]  wdata_v;
    logic [1:0][3:0]   be_v;
    logic [1:0]        ready_v;
    logic [1:0][31:0]  rdata_v;
    logic [1:0]        err_v;

    int checks   = 0;
    int failures = 0;

    // clock / reset
    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(6), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .reset(reset), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .be(be_v[0]), .ready(ready_v[0]), .rdata(rdata_v[0]), .err(err_v[0])
    );

    dmem_responder #(.ADDR_WIDTH(6), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset(reset), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .be(be_v[1]), .ready(ready_v[1]), .rdata(rdata_v[1]), .err(err_v[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Driver: one transaction; inputs are scrambled right after acceptance to
    // show that only latched values matter. Returns edges from acceptance to ready.
    task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b, output int lat, output logic [31:0] rd, output logic e);
        @(negedge clk);
        req_v[d] = 1'b1; we_v[d] = w; addr_v[d] = a; wdata_v[d] = wd; be_v[d] = b;
        @(posedge clk); #1;
        req_v[d] = 1'b0; we_v[d] = ~w; addr_v[d] = 32'hFFFF_FFFC; wdata_v[d] = '1; be_v[d] = '1;
        lat = 0; rd = 'x; e = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ready_v[d]) begin
                lat = i; rd = rdata_v[d]; e = err_v[d];
                break;
            end
        end
        @(posedge clk); #1;
        check("ready_strobe_len", {31'd0, ready_v[d]}, 32'd0);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        e;
    int          edge_n;
    int          rdy_edges [$];
    logic [31:0] rdy_data  [$];

    initial begin
        reset = 1'b0;
        req_v = 2'b11; we_v = 2'b00; addr_v = '0; wdata_v = '0; be_v = '0;

        // reset held with req=1
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_ready", {30'd0, ready_v}, 32'd0);
            check("rst_err",   {30'd0, err_v},   32'd0);
            check("rst_rdata", rdata_v[0] | rdata_v[1], 32'd0);
        end
        @(negedge clk);
        req_v = 2'b00; reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", {30'd0, ready_v}, 32'd0);

        // store then load, WAIT_CYCLES=2
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, lat, rd, e);
        check("st_lat", lat, 3);
        check("st_err", {31'd0, e}, 32'd0);
        xact(0, 1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, e);
        check("ld_lat", lat, 3);
        check("ld_err", {31'd0, e}, 32'd0);
        check("ld_data", rd, 32'hDEADBEEF);

        // byte enables; store leaves rdata unchanged
        xact(0, 1'b1, 32'h20, 32'h11223344, 4'b1111, lat, rd, e);
        check("st_keeps_rdata", rd, 32'hDEADBEEF);
        xact(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, rd, e);
        xact(0, 1'b0, 32'h20, 32'h0, 4'b1010, lat, rd, e);
        check("be_merge", rd, 32'h11BB33DD);

        // be=0000 store writes nothing
        xact(0, 1'b1, 32'h20, 32'h55555555, 4'b0000, lat, rd, e);
        check("be0_err", {31'd0, e}, 32'd0);
        xact(0, 1'b0, 32'h20, 32'h0, 4'b0000, lat, rd, e);
        check("be0_data", rd, 32'h11BB33DD);

        // errors
        xact(0, 1'b1, 32'h000, 32'h0BADF00D, 4'b1111, lat, rd, e);
        xact(0, 1'b0, 32'h102, 32'h0, 4'b0000, lat, rd, e);
        check("mis_err", {31'd0, e}, 32'd1);
        check("mis_rdata", rd, 32'd0);
        check("mis_lat", lat, 3);
        xact(0, 1'b0, 32'h20, 32'h0, 4'b0000, lat, rd, e);
        xact(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'b1111, lat, rd, e);
        check("oor_err", {31'd0, e}, 32'd1);
        check("oor_rdata", rd, 32'd0);
        xact(0, 1'b0, 32'h000, 32'h0, 4'b0000, lat, rd, e);
        check("oor_nowrite", rd, 32'h0BADF00D);
        check("oor_next_err", {31'd0, e}, 32'd0);
        xact(0, 1'b0, 32'h8000_0000, 32'h0, 4'b0000, lat, rd, e);
        check("hi_bit_err", {31'd0, e}, 32'd1);

        // WAIT_CYCLES=0 and back-to-back
        xact(1, 1'b1, 32'h04, 32'hA0A0A0A0, 4'b1111, lat, rd, e);
        check("w0_lat", lat, 1);
        xact(1, 1'b1, 32'h08, 32'hB1B1B1B1, 4'b1111, lat, rd, e);
        @(negedge clk);
        req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 32'h04;
        edge_n = 0;
        for (int i = 1; i <= 12 && rdy_edges.size() < 2; i++) begin
            @(posedge clk); #1;
            edge_n = i - 1;
            if (ready_v[1]) begin
                rdy_edges.push_back(edge_n);
                rdy_data.push_back(rdata_v[1]);
                addr_v[1] = 32'h08;
            end
        end
        req_v[1] = 1'b0;
        check("b2b_count", rdy_edges.size(), 2);
        if (rdy_edges.size() == 2) begin
            check("b2b_first_lat", rdy_edges[0], 1);
            check("b2b_spacing", rdy_edges[1] - rdy_edges[0], 3);
            check("b2b_data0", rdy_data[0], 32'hA0A0A0A0);
            check("b2b_data1", rdy_data[1], 32'hB1B1B1B1);
        end
        @(posedge clk); @(posedge clk); #1;
        check("b2b_idle", {31'd0, ready_v[1]}, 32'd0);

        // reset mid-operation aborts a store
        xact(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'b1111, lat, rd, e);
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h30; wdata_v[0] = 32'h12345678; be_v[0] = 4'b1111;
        @(posedge clk); #1;
        req_v[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("mid_rst_no_ready", {31'd0, ready_v[0]}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        xact(0, 1'b0, 32'h30, 32'h0, 4'b0000, lat, rd, e);
        check("mid_rst_data", rd, 32'hCAFEF00D);
        check("mid_rst_lat", lat, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
